merger_lane_feeder: RTL and testbench

Upstream feeder for the radix-R coordinate merger. It holds a small per-lane FIFO of sorted coordinates for each of the R merger leaves, and presents every lane head on the merger's flattened `coord_in` bus. It pops lanes on the merger's registered `fetch_next` vector and refills them from a shared fill bus. It also tracks per-lane end-of-stream, so the merger only advances when every head is final.

---
 rtl/merger_feed_pkg.sv | 27 ++
 rtl/merger_lane_fifo.sv | 96 +++++++++
 rtl/merger_lane_feeder.sv | 126 ++++++++++++
 tb/tb_merger_lane_feeder.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/merger_feed_pkg.sv
// Shared types and constants for the merger lane feeder and its per-lane FIFOs.
package merger_feed_pkg;

  typedef enum logic [1:0] {
    LANE_DONE   = 2'd0,
    LANE_ACTIVE = 2'd1,
    LANE_LAST   = 2'd2
  } lane_state_e;

  localparam int unsigned SENTINEL_MAX_BITS = 64;

  localparam int unsigned FEED_ERR_W         = 3;
  localparam int unsigned FEED_ERR_EMPTY_POP = 0;
  localparam int unsigned FEED_ERR_SENTINEL  = 1;
  localparam int unsigned FEED_ERR_UNSORTED  = 2;

  // All-ones exhausted-lane marker, truncated by the caller to the coordinate width.
  function automatic logic [SENTINEL_MAX_BITS-1:0] sentinel(input int unsigned width);
    logic [SENTINEL_MAX_BITS-1:0] v;
    v = '0;
    for (int unsigned b = 0; b < SENTINEL_MAX_BITS; b++) begin
      if (b < width) v[b] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/merger_lane_fifo.sv
// One merger lane: small circular FIFO of sorted coordinates plus its DONE/ACTIVE/LAST state.
module merger_lane_fifo
  import merger_feed_pkg::*;
#(
  parameter int unsigned COORD_BITS = 8,
  parameter int unsigned LANE_DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  pass_start,
  input  logic                  fill_sel,
  input  logic [COORD_BITS-1:0] fill_coord,
  input  logic                  fill_last,
  input  logic                  fill_nodata,
  input  logic                  pop_req,
  output logic                  fill_accept,
  output logic [COORD_BITS-1:0] head,
  output logic                  head_present,
  output logic                  lane_active,
  output logic                  lane_done,
  output logic                  lane_req
);

  localparam int unsigned PTR_W = $clog2(LANE_DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;
  localparam logic [COORD_BITS-1:0] SENTINEL = COORD_BITS'(sentinel(COORD_BITS));

  lane_state_e           state_q, state_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [OCC_W-1:0]      occ_q, occ_d;
  logic [COORD_BITS-1:0] mem_q [LANE_DEPTH];
  logic [COORD_BITS-1:0] mem_d [LANE_DEPTH];
  logic                  not_full;
  logic                  do_write;
  logic                  do_pop;

  // Acceptance uses registered occupancy, so a full lane stays closed even while popping.
  always_comb begin
    not_full    = (occ_q < OCC_W'(LANE_DEPTH));
    fill_accept = fill_sel && (state_q == LANE_ACTIVE) && not_full;
    do_write    = fill_accept && !fill_nodata;
    do_pop      = pop_req && (occ_q != '0);

    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    occ_d    = occ_q;
    mem_d    = mem_q;

    case (state_q)
      LANE_DONE:   if (pass_start) state_d = LANE_ACTIVE;
      LANE_ACTIVE: if (fill_accept && fill_last) state_d = LANE_LAST;
      LANE_LAST:   if (occ_q == '0) state_d = LANE_DONE;
      default:     state_d = LANE_DONE;
    endcase

    if (do_write) begin
      mem_d[wr_ptr_q] = fill_coord;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({do_write, do_pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase

    head_present = (occ_q != '0);
    head         = head_present ? mem_q[rd_ptr_q] : SENTINEL;
    lane_active  = (state_q == LANE_ACTIVE);
    lane_done    = (state_q == LANE_DONE);
    lane_req     = lane_active && not_full;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= LANE_DONE;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/merger_lane_feeder.sv
// Feeds MERGER_RADIX lane heads to the coordinate merger; refills lanes from a shared fill bus.
// Optional MERGER_FEED_CHECK_EN adds the sticky feed_err diagnostic output.
module merger_lane_feeder
  import merger_feed_pkg::*;
#(
  parameter int unsigned MERGER_COORD_BITS = 8,
  parameter int unsigned MERGER_RADIX      = 128,
  parameter int unsigned LANE_DEPTH        = 4
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic                                   start,
  input  logic                                   fill_valid,
  input  logic [$clog2(MERGER_RADIX)-1:0]        fill_lane,
  input  logic [MERGER_COORD_BITS-1:0]           fill_coord,
  input  logic                                   fill_last,
  input  logic                                   fill_nodata,
  output logic                                   fill_ready,
  output logic [MERGER_RADIX-1:0]                lane_req,
  output logic [MERGER_COORD_BITS*MERGER_RADIX-1:0] coord_in,
  input  logic [MERGER_RADIX-1:0]                fetch_next,
  output logic                                   heads_valid,
  output logic                                   all_done
`ifdef MERGER_FEED_CHECK_EN
  ,
  output logic [FEED_ERR_W-1:0]                  feed_err
`endif
);

  localparam int unsigned LANE_W = $clog2(MERGER_RADIX);
  localparam int unsigned B      = MERGER_COORD_BITS;

  logic [MERGER_RADIX-1:0] fill_sel;
  logic [MERGER_RADIX-1:0] fill_accept;
  logic [MERGER_RADIX-1:0] head_present;
  logic [MERGER_RADIX-1:0] lane_active;
  logic [MERGER_RADIX-1:0] lane_done;
  logic                    pass_start;

  for (genvar i = 0; i < MERGER_RADIX; i++) begin : g_lane
    assign fill_sel[i] = fill_valid && (fill_lane == LANE_W'(i));

    merger_lane_fifo #(
      .COORD_BITS (B),
      .LANE_DEPTH (LANE_DEPTH)
    ) u_lane (
      .clock        (clock),
      .reset        (reset),
      .pass_start   (pass_start),
      .fill_sel     (fill_sel[i]),
      .fill_coord   (fill_coord),
      .fill_last    (fill_last),
      .fill_nodata  (fill_nodata),
      .pop_req      (fetch_next[i]),
      .fill_accept  (fill_accept[i]),
      .head         (coord_in[i*B +: B]),
      .head_present (head_present[i]),
      .lane_active  (lane_active[i]),
      .lane_done    (lane_done[i]),
      .lane_req     (lane_req[i])
    );
  end

  // Merger may advance only when no ACTIVE lane is waiting on a refill.
  always_comb begin
    all_done    = &lane_done;
    pass_start  = start && all_done;
    heads_valid = &(head_present | ~lane_active);
    fill_ready  = |fill_accept;
  end

`ifdef MERGER_FEED_CHECK_EN
  localparam logic [B-1:0] SENTINEL = B'(sentinel(B));

  logic [MERGER_RADIX-1:0] empty_pop;
  logic [MERGER_RADIX-1:0] sent_hit;
  logic [MERGER_RADIX-1:0] unsorted;
  logic [FEED_ERR_W-1:0]   feed_err_q, feed_err_d;

  for (genvar i = 0; i < MERGER_RADIX; i++) begin : g_chk
    logic [B-1:0] prev_q, prev_d;
    logic         has_prev_q, has_prev_d;
    logic         wr;

    assign wr           = fill_accept[i] && !fill_nodata;
    assign empty_pop[i] = fetch_next[i] && !head_present[i];
    assign sent_hit[i]  = wr && (fill_coord == SENTINEL);
    assign unsorted[i]  = wr && has_prev_q && (fill_coord < prev_q);

    // Ordering history restarts with each merge pass.
    always_comb begin
      prev_d     = prev_q;
      has_prev_d = has_prev_q && !pass_start;
      if (wr) begin
        prev_d     = fill_coord;
        has_prev_d = 1'b1;
      end
    end

    always_ff @(posedge clock) begin
      if (!reset) begin
        prev_q     <= '0;
        has_prev_q <= 1'b0;
      end else begin
        prev_q     <= prev_d;
        has_prev_q <= has_prev_d;
      end
    end
  end

  always_comb begin
    feed_err_d = feed_err_q;
    if (|empty_pop) feed_err_d[FEED_ERR_EMPTY_POP] = 1'b1;
    if (|sent_hit)  feed_err_d[FEED_ERR_SENTINEL]  = 1'b1;
    if (|unsorted)  feed_err_d[FEED_ERR_UNSORTED]  = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset) feed_err_q <= '0;
    else        feed_err_q <= feed_err_d;
  end

  assign feed_err = feed_err_q;
`endif

endmodule

// File: tb/tb_merger_lane_feeder.sv
// Scoreboard bench for merger_lane_feeder (R=4, depth 2, 8-bit coords) against a queue-based lane model.
module tb_merger_lane_feeder;

  localparam int R = 4;
  localparam int D = 2;

  logic        clock;
  logic        reset;
  logic        start;
  logic        fill_valid;
  logic [1:0]  fill_lane;
  logic [7:0]  fill_coord;
  logic        fill_last;
  logic        fill_nodata;
  logic        fill_ready;
  logic [3:0]  lane_req;
  logic [31:0] coord_in;
  logic [3:0]  fetch_next;
  logic        heads_valid;
  logic        all_done;
`ifdef MERGER_FEED_CHECK_EN
  logic [2:0]  feed_err;
`endif

  merger_lane_feeder #(
    .MERGER_COORD_BITS (8),
    .MERGER_RADIX      (R),
    .LANE_DEPTH        (D)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .fill_valid  (fill_valid),
    .fill_lane   (fill_lane),
    .fill_coord  (fill_coord),
    .fill_last   (fill_last),
    .fill_nodata (fill_nodata),
    .fill_ready  (fill_ready),
    .lane_req    (lane_req),
    .coord_in    (coord_in),
    .fetch_next  (fetch_next),
    .heads_valid (heads_valid),
    .all_done    (all_done)
`ifdef MERGER_FEED_CHECK_EN
    ,
    .feed_err    (feed_err)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        fr;
    logic [31:0] coord;
    logic        hv;
    logic        ad;
    logic [3:0]  req;
    logic [2:0]  err;
  } exp_t;

  exp_t sb[$];
  exp_t me;
  int   checks = 0;
  int   errors = 0;

  // Lane model: 0 = closed (done), 1 = open, 2 = final entry seen.
  localparam int M_DONE = 0, M_ACT = 1, M_LAST = 2;
  int         mst   [R];
  logic [7:0] mq    [R][$];
  logic [7:0] mprev [R];
  logic [3:0] mhas;
  logic [2:0] merr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t predict();
    exp_t e;
    e.hv = 1'b1;
    e.ad = 1'b1;
    for (int i = 0; i < R; i++) begin
      e.coord[i*8 +: 8] = (mq[i].size() > 0) ? mq[i][0] : 8'hFF;
      if (mst[i] == M_ACT && mq[i].size() == 0) e.hv = 1'b0;
      if (mst[i] != M_DONE) e.ad = 1'b0;
      e.req[i] = (mst[i] == M_ACT) && (mq[i].size() < D);
    end
    e.fr  = fill_valid && (mst[fill_lane] == M_ACT) && (mq[fill_lane].size() < D);
    e.err = merr;
    return e;
  endfunction

  task automatic model_update();
    bit acc, alldone;
    int sz, ns;
    if (!reset) begin
      for (int i = 0; i < R; i++) begin
        mq[i].delete();
        mst[i] = M_DONE;
      end
      merr = 3'b000;
      mhas = 4'b0000;
    end else begin
      acc = fill_valid && (mst[fill_lane] == M_ACT) && (mq[fill_lane].size() < D);
      alldone = 1'b1;
      for (int i = 0; i < R; i++) if (mst[i] != M_DONE) alldone = 1'b0;
      if (start && alldone) mhas = 4'b0000;
      for (int i = 0; i < R; i++) begin
        sz = mq[i].size();
        ns = mst[i];
        if (mst[i] == M_DONE && start && alldone) ns = M_ACT;
        else if (mst[i] == M_ACT && acc && fill_lane == 2'(i) && fill_last) ns = M_LAST;
        else if (mst[i] == M_LAST && sz == 0) ns = M_DONE;
        if (fetch_next[i]) begin
          if (sz > 0) void'(mq[i].pop_front());
          else merr[0] = 1'b1;
        end
        if (acc && fill_lane == 2'(i) && !fill_nodata) begin
          if (fill_coord == 8'hFF) merr[1] = 1'b1;
          if (mhas[i] && fill_coord < mprev[i]) merr[2] = 1'b1;
          mprev[i] = fill_coord;
          mhas[i]  = 1'b1;
          mq[i].push_back(fill_coord);
        end
        mst[i] = ns;
      end
    end
  endtask

  // Drive one cycle of inputs, queue the expected outputs, then advance the model across the edge.
  task automatic step(input logic st, input logic fv, input logic [1:0] ln, input logic [7:0] cd,
                      input logic lst, input logic nd, input logic [3:0] fn, input logic rs);
    start = st; fill_valid = fv; fill_lane = ln; fill_coord = cd;
    fill_last = lst; fill_nodata = nd; fetch_next = fn; reset = rs;
    sb.push_back(predict());
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 4'h0, 1'b1);
  endtask

  task automatic fill(input logic [1:0] ln, input logic [7:0] cd, input logic [3:0] fn);
    step(1'b0, 1'b1, ln, cd, 1'b0, 1'b0, fn, 1'b1);
  endtask

  task automatic close_lane(input logic [1:0] ln);
    step(1'b0, 1'b1, ln, 8'h00, 1'b1, 1'b1, 4'h0, 1'b1);
  endtask

  // Monitor: compare the DUT against the queued expectation every cycle, mid-period.
  always @(negedge clock) begin
    if (sb.size() > 0) begin
      me = sb.pop_front();
      chk("fill_ready",  32'(fill_ready),  32'(me.fr));
      chk("coord_in",    coord_in,         me.coord);
      chk("heads_valid", 32'(heads_valid), 32'(me.hv));
      chk("all_done",    32'(all_done),    32'(me.ad));
      chk("lane_req",    32'(lane_req),    32'(me.req));
`ifdef MERGER_FEED_CHECK_EN
      chk("feed_err",    32'(feed_err),    32'(me.err));
`endif
    end
  end

  initial begin
    start = 1'b0; fill_valid = 1'b0; fill_lane = 2'd0; fill_coord = 8'h00;
    fill_last = 1'b0; fill_nodata = 1'b0; fetch_next = 4'h0; reset = 1'b0;
    @(posedge clock);
    model_update();
    #1;
    step(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 4'h0, 1'b0);

    chk("rst_coord", coord_in, 32'hFFFFFFFF);
    chk("rst_all_done", 32'(all_done), 32'd1);
    chk("rst_heads_valid", 32'(heads_valid), 32'd1);
    chk("rst_lane_req", 32'(lane_req), 32'd0);
    fill(2'd1, 8'h11, 4'h0);
    fill(2'd3, 8'h22, 4'h0);

    // Pass 1: two lanes with data, two closed empty.
    step(1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 4'h0, 1'b1);
    fill(2'd0, 8'h03, 4'h0);
    fill(2'd1, 8'h05, 4'h0);
    chk("hv_open_lanes", 32'(heads_valid), 32'd0);
    close_lane(2'd2);
    close_lane(2'd3);
    chk("hv_closed", 32'(heads_valid), 32'd1);
    chk("coord_0503", coord_in, 32'hFFFF0503);

    // Full lane refuses, including while being popped.
    fill(2'd0, 8'h07, 4'h0);
    fill(2'd0, 8'h09, 4'h0);
    fill(2'd0, 8'h09, 4'h1);
    fill(2'd0, 8'h09, 4'h1);
    chk("head_after_swap", 32'(coord_in[7:0]), 32'h09);
    close_lane(2'd0);
    close_lane(2'd1);
    step(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 4'h3, 1'b1);
    idle(1);
    chk("pass1_done", 32'(all_done), 32'd1);

    // Pass 2: single-entry last lane drains to sentinel, then DONE.
    step(1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 4'h0, 1'b1);
    step(1'b0, 1'b1, 2'd2, 8'h04, 1'b1, 1'b0, 4'h0, 1'b1);
    close_lane(2'd0);
    close_lane(2'd1);
    close_lane(2'd3);
    chk("lane2_head4", coord_in, 32'hFF04FFFF);
    step(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 4'h4, 1'b1);
    chk("lane2_sentinel", coord_in, 32'hFFFFFFFF);
    chk("lane2_still_last", 32'(all_done), 32'd0);
    idle(1);
    chk("pass2_done", 32'(all_done), 32'd1);

    // Reset mid-pass discards contents.
    step(1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 4'h0, 1'b1);
    fill(2'd0, 8'h01, 4'h0);
    fill(2'd1, 8'h02, 4'h0);
    step(1'b0, 1'b1, 2'd2, 8'h03, 1'b0, 1'b0, 4'h3, 1'b0);
    chk("midrst_coord", coord_in, 32'hFFFFFFFF);
    chk("midrst_done", 32'(all_done), 32'd1);
    step(1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 4'h0, 1'b1);
    chk("restart_req", 32'(lane_req), 32'hF);

`ifdef MERGER_FEED_CHECK_EN
    step(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 4'h1, 1'b1);
    fill(2'd0, 8'hFF, 4'h0);
    fill(2'd1, 8'h06, 4'h0);
    fill(2'd1, 8'h02, 4'h0);
    chk("feed_err_all", 32'(feed_err), 32'h7);
    idle(3);
    chk("feed_err_sticky", 32'(feed_err), 32'h7);
`endif

    // Randomized traffic, including occasional resets and pops of empty lanes.
    for (int n = 0; n < 3000; n++) begin
      step(1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 1)),
           2'($urandom_range(0, 3)),
           8'($urandom_range(0, 255)),
           1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 1)),
           4'($urandom_range(0, 15)),
           1'($urandom_range(0, 299) != 0));
    end
    idle(1);
    @(negedge clock);
    #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
